// File: rtl/first_round_key_gen_pkg.sv
// Shared types, constants and helpers for the first-round key stage of the Rijndael key schedule.
package first_round_key_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    localparam int KC4 = 4;
    localparam int KC6 = 6;
    localparam int KC8 = 8;

    localparam int WORD_W_DEF    = 32;
    localparam int BLK_WORDS_DEF = 4;

    // Rows of 4 words needed to hold kc key words, i.e. ceil(kc/4).
    function automatic logic [2:0] nrows(input logic [3:0] kc);
        logic [4:0] t;
        t = {1'b0, kc} + 5'd3;
        return t[4:2];
    endfunction

    function automatic logic kc_legal(input logic [3:0] kc);
        return (int'(kc) == KC4) || (int'(kc) == KC6) || (int'(kc) == KC8);
    endfunction

endpackage

// File: rtl/first_round_key_gen_if.sv
// Load request and RAM write/completion bus of first_round_key_gen.
interface first_round_key_gen_if #(
    parameter int WORD_W        = first_round_key_pkg::WORD_W_DEF,
    parameter int BLK_WORDS     = first_round_key_pkg::BLK_WORDS_DEF,
    parameter int KEY_WORDS_MAX = 8,
    parameter int ADDR_W        = 4
);
    logic [3:0]                      iKC;
    logic [3:0]                      iRound;
    logic                            iKey_load;
    logic [KEY_WORDS_MAX*WORD_W-1:0] iKey_data;

    logic                            oBusy;
    logic                            oErr;
    logic [ADDR_W-1:0]               oRAM_Ke_addr;
    logic [BLK_WORDS-1:0]            oRAM_Ke_we;
    logic [BLK_WORDS*WORD_W-1:0]     oRAM_Ke_data;
    logic [ADDR_W-1:0]               oRAM_Kd_addr;
    logic [BLK_WORDS-1:0]            oRAM_Kd_we;
    logic [BLK_WORDS*WORD_W-1:0]     oRAM_Kd_data;
    logic                            oLast_key_data_valid;
    logic [WORD_W-1:0]               oLast_key_data;
    logic [KEY_WORDS_MAX*WORD_W-1:0] oKey_words;
    logic [ADDR_W-1:0]               oNext_row;
    logic [1:0]                      oNext_lane;

    modport master (
        output iKC, iRound, iKey_load, iKey_data,
        input  oBusy, oErr, oRAM_Ke_addr, oRAM_Ke_we, oRAM_Ke_data,
               oRAM_Kd_addr, oRAM_Kd_we, oRAM_Kd_data,
               oLast_key_data_valid, oLast_key_data, oKey_words, oNext_row, oNext_lane
    );

    modport slave (
        input  iKC, iRound, iKey_load, iKey_data,
        output oBusy, oErr, oRAM_Ke_addr, oRAM_Ke_we, oRAM_Ke_data,
               oRAM_Kd_addr, oRAM_Kd_we, oRAM_Kd_data,
               oLast_key_data_valid, oLast_key_data, oKey_words, oNext_row, oNext_lane
    );
endinterface

// File: rtl/first_round_key_gen_key_row_mux.sv
// Combinational row selector: key words 4r..4r+3 plus per-lane enables for words below KC.
module key_row_mux #(
    parameter int WORD_W        = 32,
    parameter int BLK_WORDS     = 4,
    parameter int KEY_WORDS_MAX = 8,
    parameter int ADDR_W        = 4
) (
    input  logic [KEY_WORDS_MAX*WORD_W-1:0] key_words,
    input  logic [ADDR_W-1:0]               row,
    input  logic [3:0]                      kc,
    output logic [BLK_WORDS*WORD_W-1:0]     data,
    output logic [BLK_WORDS-1:0]            we
);

    // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
    always_comb begin
        data = '0;
        we   = '0;
        for (int i = 0; i < BLK_WORDS; i++) begin
            if (int'(row) * BLK_WORDS + i < KEY_WORDS_MAX)
                data[i*WORD_W +: WORD_W] = key_words[(int'(row) * BLK_WORDS + i) * WORD_W +: WORD_W];
            we[i] = (int'(row) * BLK_WORDS + i) < int'(kc);
        end
    end

endmodule

// File: rtl/first_round_key_gen.sv
// First-round key writer for 4/6/8-word keys into Ke (row 0 up) and Kd (row iRound down).
// Define KD_WRITE_EN to drive the Kd port; otherwise the build is encrypt-only.
module first_round_key_gen
    import first_round_key_pkg::*;
#(
    parameter int WORD_W        = WORD_W_DEF,
    parameter int BLK_WORDS     = BLK_WORDS_DEF,
    parameter int KEY_WORDS_MAX = 8,
    parameter int ADDR_W        = 4
) (
    input logic                 iClk,
    input logic                 iRst_n,
    first_round_key_gen_if.slave bus
);

    localparam int KEY_W = KEY_WORDS_MAX * WORD_W;
    localparam int ROW_W = BLK_WORDS * WORD_W;

    state_e              state;
    logic [KEY_W-1:0]    key_q;
    logic [3:0]          kc_q;
    logic [ADDR_W-1:0]   row_q;
    logic [ADDR_W-1:0]   last_row_q;
    logic [ADDR_W-1:0]   ke_addr_q;
    logic [BLK_WORDS-1:0] we_q;
    logic [ROW_W-1:0]    data_q;
    logic                busy_q;
    logic                err_q;
    logic                valid_q;
    logic [WORD_W-1:0]   last_word_q;
    logic [ADDR_W-1:0]   next_row_q;
    logic [1:0]          next_lane_q;

    logic                idle;
    logic [KEY_W-1:0]    mux_key;
    logic [3:0]          mux_kc;
    logic [ADDR_W-1:0]   mux_row;
    logic [ROW_W-1:0]    row_data;
    logic [BLK_WORDS-1:0] row_we;
    logic [WORD_W-1:0]   last_word_in;

    // Row 0 is registered on the load edge itself, so in IDLE the mux looks at the incoming key.
    assign idle    = (state == ST_IDLE);
    assign mux_key = idle ? bus.iKey_data : key_q;
    assign mux_kc  = idle ? bus.iKC : kc_q;
    assign mux_row = idle ? '0 : row_q;

    key_row_mux #(
        .WORD_W       (WORD_W),
        .BLK_WORDS    (BLK_WORDS),
        .KEY_WORDS_MAX(KEY_WORDS_MAX),
        .ADDR_W       (ADDR_W)
    ) u_key_row_mux (
        .key_words(mux_key),
        .row      (mux_row),
        .kc       (mux_kc),
        .data     (row_data),
        .we       (row_we)
    );

    always_comb begin
        last_word_in = '0;
        for (int w = 0; w < KEY_WORDS_MAX; w++)
            if (w == int'(bus.iKC) - 1) last_word_in = bus.iKey_data[w*WORD_W +: WORD_W];
    end

`ifdef KD_WRITE_EN
    logic [3:0]        round_q;
    logic [ADDR_W-1:0] kd_addr_q;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            // NOTE: the key buffer is a plain register bank, so it is cleared with the rest of the state.
            state       <= ST_IDLE;
            key_q       <= '0;
            kc_q        <= '0;
            row_q       <= '0;
            last_row_q  <= '0;
            ke_addr_q   <= '0;
            we_q        <= '0;
            data_q      <= '0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
            valid_q     <= 1'b0;
            last_word_q <= '0;
            next_row_q  <= '0;
            next_lane_q <= '0;
`ifdef KD_WRITE_EN
            round_q     <= '0;
            kd_addr_q   <= '0;
`endif
        end else begin
            we_q    <= '0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.iKey_load) begin
                        if (kc_legal(bus.iKC)) begin
                            key_q       <= bus.iKey_data;
                            kc_q        <= bus.iKC;
                            ke_addr_q   <= '0;
                            data_q      <= row_data;
                            we_q        <= row_we;
                            last_word_q <= last_word_in;
                            next_row_q  <= ADDR_W'(bus.iKC >> 2);
                            next_lane_q <= bus.iKC[1:0];
                            busy_q      <= 1'b1;
                            row_q       <= ADDR_W'(1);
                            last_row_q  <= ADDR_W'(nrows(bus.iKC) - 3'd1);
                            state       <= (nrows(bus.iKC) == 3'd1) ? ST_DONE : ST_WRITE;
`ifdef KD_WRITE_EN
                            round_q     <= bus.iRound;
                            kd_addr_q   <= ADDR_W'(bus.iRound);
`endif
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                ST_WRITE: begin
                    ke_addr_q <= row_q;
                    data_q    <= row_data;
                    we_q      <= row_we;
                    row_q     <= row_q + ADDR_W'(1);
`ifdef KD_WRITE_EN
                    kd_addr_q <= ADDR_W'(round_q) - row_q;
`endif
                    if (row_q == last_row_q) state <= ST_DONE;
                end
                ST_DONE: begin
                    valid_q <= 1'b1;
                    busy_q  <= 1'b0;
                    state   <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.oBusy                = busy_q;
    assign bus.oErr                 = err_q;
    assign bus.oRAM_Ke_addr         = ke_addr_q;
    assign bus.oRAM_Ke_we           = we_q;
    assign bus.oRAM_Ke_data         = data_q;
    assign bus.oLast_key_data_valid = valid_q;
    assign bus.oLast_key_data       = last_word_q;
    assign bus.oKey_words           = key_q;
    assign bus.oNext_row            = next_row_q;
    assign bus.oNext_lane           = next_lane_q;

`ifdef KD_WRITE_EN
    assign bus.oRAM_Kd_addr = kd_addr_q;
    assign bus.oRAM_Kd_we   = we_q;
    assign bus.oRAM_Kd_data = data_q;
`else
    logic unused_round;
    assign unused_round     = ^bus.iRound;
    assign bus.oRAM_Kd_addr = '0;
    assign bus.oRAM_Kd_we   = '0;
    assign bus.oRAM_Kd_data = '0;
`endif

endmodule

// File: tb/tb_first_round_key_gen.sv
// Scoreboard bench for first_round_key_gen: row writes and completions checked against expectations queued at load time.
module tb_first_round_key_gen;
    import first_round_key_pkg::*;

    localparam int WORD_W = 32;
    localparam int BLK_WORDS = 4;
    localparam int KW = 8;
    localparam int ADDR_W = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    first_round_key_gen_if #(.WORD_W(WORD_W), .BLK_WORDS(BLK_WORDS), .KEY_WORDS_MAX(KW), .ADDR_W(ADDR_W)) bus ();

    first_round_key_gen #(.WORD_W(WORD_W), .BLK_WORDS(BLK_WORDS), .KEY_WORDS_MAX(KW), .ADDR_W(ADDR_W)) dut (
        .iClk  (clk),
        .iRst_n(rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [3:0]   ke_addr;
        logic [3:0]   kd_addr;
        logic [3:0]   we;
        logic [3:0]   kd_we;
        logic [127:0] data;
        logic [127:0] kd_data;
    } row_t;

    typedef struct {
        logic [31:0]  last;
        logic [3:0]   next_row;
        logic [1:0]   next_lane;
        logic [255:0] words;
    } done_t;

    row_t  row_sb[$];
    done_t done_sb[$];
    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected RAM rows and completion for a load of kc words.
    task automatic push_expect(input int kc, input int round, input logic [255:0] key,
                               input int rows, input bit with_done);
        for (int r = 0; r < rows; r++) begin
            row_t e;
            e.ke_addr = 4'(r);
            e.data    = key[r*128 +: 128];
            for (int i = 0; i < 4; i++) e.we[i] = (4*r + i) < kc;
`ifdef KD_WRITE_EN
            e.kd_addr = 4'(round - r);
            e.kd_we   = e.we;
            e.kd_data = e.data;
`else
            e.kd_addr = 4'd0;
            e.kd_we   = 4'd0;
            e.kd_data = '0;
`endif
            row_sb.push_back(e);
        end
        if (with_done) begin
            done_t d;
            d.last      = key[(kc-1)*32 +: 32];
            d.next_row  = 4'(kc / 4);
            d.next_lane = 2'(kc % 4);
            d.words     = key;
            done_sb.push_back(d);
        end
    endtask

    always @(negedge clk) begin
        if (bus.oRAM_Ke_we != 4'd0) begin
            if (row_sb.size() == 0) begin
                check("unexpected_write", 256'(bus.oRAM_Ke_we), 256'd0);
            end else begin
                row_t e;
                e = row_sb.pop_front();
                check("ke_addr", 256'(bus.oRAM_Ke_addr), 256'(e.ke_addr));
                check("ke_we",   256'(bus.oRAM_Ke_we),   256'(e.we));
                check("ke_data", 256'(bus.oRAM_Ke_data), 256'(e.data));
                check("kd_addr", 256'(bus.oRAM_Kd_addr), 256'(e.kd_addr));
                check("kd_we",   256'(bus.oRAM_Kd_we),   256'(e.kd_we));
                check("kd_data", 256'(bus.oRAM_Kd_data), 256'(e.kd_data));
            end
        end
        if (bus.oLast_key_data_valid) begin
            if (done_sb.size() == 0) begin
                check("unexpected_valid", 256'(bus.oLast_key_data_valid), 256'd0);
            end else begin
                done_t d;
                d = done_sb.pop_front();
                check("last_key",  256'(bus.oLast_key_data), 256'(d.last));
                check("next_row",  256'(bus.oNext_row),      256'(d.next_row));
                check("next_lane", 256'(bus.oNext_lane),     256'(d.next_lane));
                check("key_words", bus.oKey_words,           d.words);
            end
        end
    end

    task automatic run_load(input int kc, input int round, input logic [255:0] key);
        int n;
        n = (kc + 3) / 4;
        push_expect(kc, round, key, n, 1'b1);
        bus.iKC = 4'(kc);
        bus.iRound = 4'(round);
        bus.iKey_data = key;
        bus.iKey_load = 1'b1;
        tick();
        bus.iKey_load = 1'b0;
        check("busy_c1", 256'(bus.oBusy), 256'd1);
        check("we_c1", 256'(bus.oRAM_Ke_we), 256'hF);
        check("words_c1", bus.oKey_words, key);
        for (int r = 1; r < n; r++) begin
            tick();
            check("row_addr", 256'(bus.oRAM_Ke_addr), 256'(r));
        end
        tick();
        check("valid_on_time", 256'(bus.oLast_key_data_valid), 256'd1);
        tick();
        check("valid_drop", 256'(bus.oLast_key_data_valid), 256'd0);
        check("we_idle", 256'(bus.oRAM_Ke_we), 256'd0);
        check("busy_idle", 256'(bus.oBusy), 256'd0);
    endtask

    function automatic logic [255:0] rand_key();
        logic [255:0] k;
        for (int i = 0; i < 8; i++) k[i*32 +: 32] = $urandom;
        return k;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] key_a;
        logic [255:0] key_b;

        bus.iKC = '0;
        bus.iRound = '0;
        bus.iKey_load = 1'b0;
        bus.iKey_data = '0;
        rst_n = 1'b0;
        repeat (2) tick();

        check("rst_ke_we",   256'(bus.oRAM_Ke_we), 256'd0);
        check("rst_ke_addr", 256'(bus.oRAM_Ke_addr), 256'd0);
        check("rst_ke_data", 256'(bus.oRAM_Ke_data), 256'd0);
        check("rst_kd_addr", 256'(bus.oRAM_Kd_addr), 256'd0);
        check("rst_busy",    256'(bus.oBusy), 256'd0);
        check("rst_err",     256'(bus.oErr), 256'd0);
        check("rst_valid",   256'(bus.oLast_key_data_valid), 256'd0);
        check("rst_words",   bus.oKey_words, 256'd0);
        check("rst_next",    256'({bus.oNext_row, bus.oNext_lane}), 256'd0);
        rst_n = 1'b1;
        tick();

        key_a = rand_key();
        key_a[127:0] = 128'h0C0D0E0F_08090A0B_04050607_00010203;
        run_load(4, 10, key_a);
        run_load(6, 12, rand_key());
        run_load(8, 14, rand_key());

        // Illegal key length.
        bus.iKC = 4'd5;
        bus.iRound = 4'd10;
        bus.iKey_data = rand_key();
        bus.iKey_load = 1'b1;
        tick();
        bus.iKey_load = 1'b0;
        check("err_pulse", 256'(bus.oErr), 256'd1);
        check("err_busy",  256'(bus.oBusy), 256'd0);
        check("err_we",    256'(bus.oRAM_Ke_we), 256'd0);
        tick();
        check("err_drop",  256'(bus.oErr), 256'd0);
        check("err_valid", 256'(bus.oLast_key_data_valid), 256'd0);
        tick();

        // Second load while busy is ignored.
        key_a = rand_key();
        key_b = rand_key();
        push_expect(8, 14, key_a, 2, 1'b1);
        bus.iKC = 4'd8;
        bus.iRound = 4'd14;
        bus.iKey_data = key_a;
        bus.iKey_load = 1'b1;
        tick();
        bus.iKC = 4'd4;
        bus.iRound = 4'd10;
        bus.iKey_data = key_b;
        check("dbl_busy", 256'(bus.oBusy), 256'd1);
        tick();
        bus.iKey_load = 1'b0;
        check("dbl_row1",  256'(bus.oRAM_Ke_addr), 256'd1);
        check("dbl_words", bus.oKey_words, key_a);
        check("dbl_err",   256'(bus.oErr), 256'd0);
        tick();
        check("dbl_valid", 256'(bus.oLast_key_data_valid), 256'd1);
        check("dbl_last",  256'(bus.oLast_key_data), 256'(key_a[255:224]));
        tick();
        tick();

        // Reset during a KC=8 operation, after row 0.
        key_a = rand_key();
        push_expect(8, 14, key_a, 1, 1'b0);
        bus.iKC = 4'd8;
        bus.iRound = 4'd14;
        bus.iKey_data = key_a;
        bus.iKey_load = 1'b1;
        tick();
        bus.iKey_load = 1'b0;
        rst_n = 1'b0;
        check("mid_we_c1", 256'(bus.oRAM_Ke_we), 256'hF);
        tick();
        check("mid_we",    256'(bus.oRAM_Ke_we), 256'd0);
        check("mid_addr",  256'(bus.oRAM_Ke_addr), 256'd0);
        check("mid_busy",  256'(bus.oBusy), 256'd0);
        check("mid_words", bus.oKey_words, 256'd0);
        check("mid_last",  256'(bus.oLast_key_data), 256'd0);
        rst_n = 1'b1;
        tick();
        tick();
        check("mid_novalid", 256'(bus.oLast_key_data_valid), 256'd0);

        run_load(6, 12, rand_key());

        repeat (3) tick();
        check("rows_drained", 256'(row_sb.size()), 256'd0);
        check("done_drained", 256'(done_sb.size()), 256'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
